// File: rtl/power_req_ctrl_pkg.sv
// pwr_ctrl_pkg: encodings shared by the power request controller and the shut-off sequencer
package pwr_ctrl_pkg;
  localparam int DEF_IDLE_W = 16;
  typedef enum logic [1:0] {RUN = 2'd0, REQ = 2'd1, SLEEP = 2'd2, WAKE = 2'd3} pwr_state_e;
  typedef enum logic [1:0] {SEQ_ON = 2'd0, SEQ_ISOLATE = 2'd1, SEQ_OFF = 2'd2, SEQ_RESTORE = 2'd3} seq_state_e;
  function automatic logic holds_req(pwr_state_e s);
    return s == REQ || s == SLEEP;
  endfunction
endpackage

// File: rtl/power_req_ctrl_if.sv
// power_req_ctrl_if: request/status handshake between the controller and the shut-off sequencer
interface power_req_ctrl_if;
  logic L1_module_req;
  logic set_status_module;
  logic clr_status_module;
  modport master (output L1_module_req, input set_status_module, clr_status_module);
  modport slave (input L1_module_req, output set_status_module, clr_status_module);
endinterface

// File: rtl/power_req_ctrl_idle_timer.sv
// idle_timer: saturating idle counter with terminal-count compare against the threshold
module idle_timer #(
  parameter int IDLE_W = 16
) (
  input  logic              pclk,
  input  logic              nprst,
  input  logic              clr,
  input  logic              en,
  input  logic [IDLE_W-1:0] thresh,
  output logic              tc
);
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  always_comb idle_cnt_d = clr ? '0 : (en && !(&idle_cnt_q)) ? idle_cnt_q + IDLE_W'(1) : idle_cnt_q;
  always_ff @(posedge pclk or negedge nprst)
    if (!nprst) idle_cnt_q <= '0;
    else idle_cnt_q <= idle_cnt_d;
  // fires on the cycle that completes thresh consecutive idle cycles
  assign tc = en && idle_cnt_q == thresh - IDLE_W'(1);
endmodule

// File: rtl/power_req_ctrl.sv
// power_req_ctrl: raises/drops the L1 shut-off request, tracks L1 status and
// produces entry/exit interrupt pulses for one power-gated module
module power_req_ctrl
  import pwr_ctrl_pkg::*;
#(
  parameter int IDLE_W = DEF_IDLE_W
) (
  input  logic              pclk,
  input  logic              nprst,
  input  logic              sw_enter,
  input  logic              sw_exit,
  input  logic              auto_en,
  input  logic [IDLE_W-1:0] idle_thresh,
  input  logic              module_idle,
  input  logic              wakeup_evt,
  power_req_ctrl_if.master  seq,
  output logic              L1_status,
  output logic              irq_entered,
  output logic              irq_exited,
  output logic              busy
);
  pwr_state_e state_q, state_d;
  logic wake_pend_q, wake_pend_d;
  logic req_q, req_d;
  logic status_q, status_d;
  logic entered_q, entered_d;
  logic exited_q, exited_d;
  logic busy_q, busy_d;
  logic in_run, cnt_en, cnt_clr, auto_hit;
  assign in_run  = state_q == RUN;
  assign cnt_en  = in_run && auto_en && module_idle && !wakeup_evt && idle_thresh != '0;
  assign cnt_clr = !in_run || !auto_en || !module_idle || wakeup_evt;
  idle_timer #(.IDLE_W(IDLE_W)) u_idle_timer (
    .pclk  (pclk),
    .nprst (nprst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .thresh(idle_thresh),
    .tc    (auto_hit)
  );
  always_ff @(posedge pclk or negedge nprst)
    if (!nprst) begin
      state_q     <= RUN;
      wake_pend_q <= 1'b0;
      req_q       <= 1'b0;
      status_q    <= 1'b0;
      entered_q   <= 1'b0;
      exited_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wake_pend_q <= wake_pend_d;
      req_q       <= req_d;
      status_q    <= status_d;
      entered_q   <= entered_d;
      exited_q    <= exited_d;
      busy_q      <= busy_d;
    end
  // a wake seen in REQ is parked so the sequencer always completes the entry it started
  always_comb begin
    state_d     = state_q;
    wake_pend_d = wake_pend_q;
    case (state_q)
      RUN:   state_d = (!sw_exit && (sw_enter || auto_hit)) ? REQ : RUN;
      REQ: begin
        wake_pend_d = wake_pend_q || sw_exit || wakeup_evt;
        state_d     = seq.set_status_module ? SLEEP : REQ;
      end
      SLEEP: begin
        state_d     = (wake_pend_q || wakeup_evt || sw_exit) ? WAKE : SLEEP;
        wake_pend_d = state_d == SLEEP && wake_pend_q;
      end
      WAKE:  state_d = seq.clr_status_module ? RUN : WAKE;
    endcase
  end
  always_comb begin
    req_d     = holds_req(state_d);
    busy_d    = state_d != RUN;
    entered_d = state_q == REQ && seq.set_status_module;
    exited_d  = state_q == WAKE && seq.clr_status_module;
    status_d  = entered_d ? 1'b1 : exited_d ? 1'b0 : status_q;
  end
  assign seq.L1_module_req = req_q;
  assign L1_status         = status_q;
  assign irq_entered       = entered_q;
  assign irq_exited        = exited_q;
  assign busy              = busy_q;
  a_irq_excl: assert property (@(posedge pclk) disable iff (!nprst) !(irq_entered && irq_exited));
  a_req_fall: assert property (@(posedge pclk) disable iff (!nprst) $fell(seq.L1_module_req) |-> state_q == WAKE);
  a_status_rise: assert property (@(posedge pclk) disable iff (!nprst) $rose(L1_status) |-> $past(seq.set_status_module));
  c_spurious_set: cover property (@(posedge pclk) disable iff (!nprst) seq.set_status_module && state_q != REQ);
  c_spurious_clr: cover property (@(posedge pclk) disable iff (!nprst) seq.clr_status_module && state_q != WAKE);
endmodule

// File: tb/tb_power_req_ctrl.sv
// tb_power_req_ctrl: directed stimulus with an event scoreboard on the output vector
// {L1_module_req, L1_status, irq_entered, irq_exited, busy}
module tb_power_req_ctrl;
  logic pclk = 1'b0, nprst = 1'b1;
  logic sw_enter = 1'b0, sw_exit = 1'b0, auto_en = 1'b0, module_idle = 1'b0, wakeup_evt = 1'b0;
  logic [15:0] idle_thresh = 16'd0;
  logic L1_status, irq_entered, irq_exited, busy;
  power_req_ctrl_if seq();
  power_req_ctrl #(.IDLE_W(16)) dut (
    .pclk(pclk), .nprst(nprst), .sw_enter(sw_enter), .sw_exit(sw_exit), .auto_en(auto_en),
    .idle_thresh(idle_thresh), .module_idle(module_idle), .wakeup_evt(wakeup_evt), .seq(seq),
    .L1_status(L1_status), .irq_entered(irq_entered), .irq_exited(irq_exited), .busy(busy)
  );
  localparam logic [4:0] EN = 5'b10000, EX = 5'b01000, WK = 5'b00100, SS = 5'b00010, CS = 5'b00001;
  typedef struct {int c; logic [4:0] v;} ev_t;
  ev_t q[$];
  ev_t e;
  int cyc = 0, checks = 0, failures = 0;
  int t;
  logic [4:0] prev = '0, cur;
  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;
  function automatic logic [4:0] outs();
    return {seq.L1_module_req, L1_status, irq_entered, irq_exited, busy};
  endfunction
  task automatic check(string n, int got, int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", n, got, want, cyc);
    end
  endtask
  task automatic expect_ev(int c, logic [4:0] v);
    q.push_back('{c: c, v: v});
  endtask
  task automatic go(int c);
    while (cyc < c) @(negedge pclk);
  endtask
  task automatic pulse(int c, logic [4:0] m);
    go(c);
    {sw_enter, sw_exit, wakeup_evt, seq.set_status_module, seq.clr_status_module} = m;
    go(c + 1);
    {sw_enter, sw_exit, wakeup_evt, seq.set_status_module, seq.clr_status_module} = '0;
  endtask
  // r is the cycle the request became visible; completes entry, exits by software
  task automatic finish_seq(int r);
    expect_ev(r + 2, 5'b11101);
    expect_ev(r + 3, 5'b11001);
    expect_ev(r + 5, 5'b01001);
    expect_ev(r + 8, 5'b00010);
    expect_ev(r + 9, 5'b00000);
    pulse(r + 1, SS);
    go(r + 4);
    auto_en = 1'b0;
    module_idle = 1'b0;
    pulse(r + 4, EX);
    pulse(r + 7, CS);
    go(r + 11);
  endtask
  always @(negedge pclk) begin
    cur = outs();
    if (!nprst) prev = '0;
    else if (cur != prev) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: got %b, want %b (cycle %0d)", cur, prev, cyc);
      end else begin
        e = q.pop_front();
        check("evt_cycle", cyc, e.c);
        check("evt_value", int'(cur), int'(e.v));
      end
      prev = cur;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    seq.set_status_module = 1'b0;
    seq.clr_status_module = 1'b0;
    #2 nprst = 1'b0;
    #1 check("reset_outs", int'(outs()), 0);
    repeat (3) @(negedge pclk);
    nprst = 1'b1;
    @(negedge pclk);
    check("post_reset_outs", int'(outs()), 0);
    // software entry, wake event, power-up complete
    t = cyc + 1;
    expect_ev(t + 1, 5'b10001);
    expect_ev(t + 3, 5'b11101);
    expect_ev(t + 4, 5'b11001);
    expect_ev(t + 11, 5'b01001);
    expect_ev(t + 41, 5'b00010);
    expect_ev(t + 42, 5'b00000);
    pulse(t, EN);
    pulse(t + 2, SS);
    pulse(t + 10, WK);
    go(t + 20);
    check("status_mid_sleep", int'(L1_status), 1);
    pulse(t + 40, CS);
    go(t + 45);
    // auto entry after exactly five idle cycles
    t = cyc + 1;
    expect_ev(t + 5, 5'b10001);
    go(t);
    auto_en = 1'b1;
    module_idle = 1'b1;
    idle_thresh = 16'd5;
    finish_seq(t + 5);
    // idle drop after two counted cycles restarts the count
    t = cyc + 1;
    expect_ev(t + 8, 5'b10001);
    go(t);
    auto_en = 1'b1;
    module_idle = 1'b1;
    go(t + 2);
    module_idle = 1'b0;
    go(t + 3);
    module_idle = 1'b1;
    finish_seq(t + 8);
    // wake during REQ is held until the entry is accepted
    t = cyc + 1;
    expect_ev(t + 1, 5'b10001);
    expect_ev(t + 5, 5'b11101);
    expect_ev(t + 6, 5'b01001);
    expect_ev(t + 9, 5'b00010);
    expect_ev(t + 10, 5'b00000);
    pulse(t, EN);
    pulse(t + 2, WK);
    pulse(t + 4, SS);
    pulse(t + 8, CS);
    go(t + 12);
    // set_status and wake in the same REQ cycle
    t = cyc + 1;
    expect_ev(t + 1, 5'b10001);
    expect_ev(t + 4, 5'b11101);
    expect_ev(t + 5, 5'b01001);
    expect_ev(t + 8, 5'b00010);
    expect_ev(t + 9, 5'b00000);
    pulse(t, EN);
    pulse(t + 3, SS | WK);
    pulse(t + 7, CS);
    go(t + 11);
    // enter and exit together: exit wins
    t = cyc + 1;
    pulse(t, EN | EX);
    go(t + 3);
    check("enter_exit_no_req", int'(seq.L1_module_req), 0);
    // threshold zero disables auto entry
    auto_en = 1'b1;
    module_idle = 1'b1;
    idle_thresh = 16'd0;
    go(t + 1003);
    check("thresh0_no_req", int'(seq.L1_module_req), 0);
    check("thresh0_not_busy", int'(busy), 0);
    auto_en = 1'b0;
    module_idle = 1'b0;
    idle_thresh = 16'd5;
    // spurious clr_status in RUN, spurious set_status in SLEEP
    t = cyc + 1;
    pulse(t, CS);
    go(t + 3);
    check("spurious_clr_outs", int'(outs()), 0);
    t = cyc + 1;
    expect_ev(t + 1, 5'b10001);
    expect_ev(t + 3, 5'b11101);
    expect_ev(t + 4, 5'b11001);
    pulse(t, EN);
    pulse(t + 2, SS);
    pulse(t + 6, SS);
    go(t + 9);
    check("spurious_set_outs", int'(outs()), 5'b11001);
    // asynchronous reset while in SLEEP
    #2 nprst = 1'b0;
    #1 check("async_reset_outs", int'(outs()), 0);
    check("sb_empty_at_reset", q.size(), 0);
    @(negedge pclk);
    @(negedge pclk);
    nprst = 1'b1;
    t = cyc + 1;
    expect_ev(t + 1, 5'b10001);
    expect_ev(t + 3, 5'b11101);
    expect_ev(t + 4, 5'b11001);
    expect_ev(t + 6, 5'b01001);
    expect_ev(t + 9, 5'b00010);
    expect_ev(t + 10, 5'b00000);
    pulse(t, EN);
    pulse(t + 2, SS);
    pulse(t + 5, EX);
    pulse(t + 8, CS);
    go(t + 13);
    check("sb_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
